parallel_to_serial: RTL and testbench
=====================================

# parallel_to_serial

- Converts `IN_WIDTH`-bit parallel words into a 1-bit serial stream. Both sides use a valid/ready handshake.
- Sits directly upstream of `serial_to_parallel`. Its serial output connects to that block's `s_valid`/`s_ready`/`s_data`, so a word sent through both blocks comes back unchanged.
- A one-word hold buffer lets the next word be accepted while the current one shifts out, so the serial side runs at 1 bit/cycle without bubbles.

## Interface
Parameters:
- `IN_WIDTH`, default 8: parallel word width; legal range ≥ 2.

Ports:
- `clk` in 1: sole clock, rising edge.
- `aresetn` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: parallel word offered.
- `s_ready` out 1: block can take a word.
- `s_data` in `IN_WIDTH`: parallel word.
- `m_valid` out 1: serial bit offered.
- `m_ready` in 1: downstream takes the bit.
- `m_data` out 1: current serial bit.
- `m_last` out 1: current bit is the final bit of its word.

## Operation
State:
- shift register `shift_ff[IN_WIDTH-1:0]`
- bit counter `cnt`, width `$clog2(IN_WIDTH)`, counting 0..`IN_WIDTH-1`
- `busy` flag (shifter holds a word)
- hold register `hold_ff`
- `hold_valid` flag

Definitions:
- Accept = `s_valid & s_ready`.
- Bit handshake = `m_valid & m_ready`.
- End = bit handshake while `cnt == IN_WIDTH-1`.

Combinational outputs:
- `s_ready = ~hold_valid`
- `m_valid = busy`
- `m_last = busy & (cnt == IN_WIDTH-1)`
- `m_data = shift_ff[0]` (LSB-first, default build)

Shifter free condition: `~busy | End`.

Accept behaviour:
- Accept and shifter free: load `s_data` straight into `shift_ff`; set `cnt = 0`, `busy = 1`. Hold stays empty.
- Accept and shifter not free: write `s_data` into `hold_ff`; set `hold_valid = 1`.

Bit handshake, not End: shift `shift_ff` toward the output bit by one; `cnt + 1`.

End behaviour, priority in this order:
1. `hold_valid`: load `hold_ff` into the shifter, clear `hold_valid`, `cnt = 0`, `busy` stays 1.
2. Else accept this cycle: take the direct-load path above.
3. Else `busy = 0`, `cnt = 0`.

Fixed rules:
- Accept with `hold_valid = 1` cannot occur, because `s_ready = 0`.
- `cnt` wraps explicitly at `IN_WIDTH-1`, including non-power-of-two widths.
- `m_data` and `m_last` stay stable while `m_valid & ~m_ready`.
- `s_data` is sampled only on accept.

Reset (asynchronous, any time including mid-word):
- All registers clear to 0.
- Outputs: `m_valid = 0`, `m_data = 0`, `m_last = 0`, `s_ready = 1`.
- Partly sent and held words are discarded.

## Timing
- Latency: word accepted at edge N gives `m_valid = 1` with bit 0 after edge N, when the shifter was free.
- Throughput: with `m_ready` held at 1 and `s_valid` held at 1, `m_valid` stays 1 continuously; one word every `IN_WIDTH` cycles.
- `s_ready` falls the cycle after a word enters hold. It rises the cycle after the End that drains hold.
- No combinational path from `m_ready` or `s_valid` to any output.

## Configuration
Macro `PARALLEL_TO_SERIAL_MSB_FIRST_EN`:
- Undefined (default): LSB-first. `m_data = shift_ff[0]`, shift right. Matches `serial_to_parallel` packing.
- Defined: MSB-first. `m_data = shift_ff[IN_WIDTH-1]`, shift left.
- `m_last`, counter and handshake behaviour are identical in both builds.

## Test plan
All scenarios use `IN_WIDTH = 8` unless stated.
1. Reset, then idle → `s_ready = 1`, `m_valid = 0`, `m_data = 0`, `m_last = 0`. Send word 0xA5 with `m_ready = 1` → bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; `m_last = 1` only on the 8th.
2. Words 0x3C then 0xFF back-to-back, `m_ready = 1` → 16 consecutive valid bits with no gap. `s_ready` is 0 from the cycle after 0xFF is held until the first End.
3. Random `m_ready` (50%) while sending 0x81 → `m_data` and `m_last` never change while stalled; 8 handshakes deliver 1,0,0,0,0,0,0,1.
4. Assert `aresetn = 0` after 3 bits of 0xF0 with 0x0F held → outputs return to reset values asynchronously. After release, only newly sent words appear.
5. Loopback into `serial_to_parallel`, 100 random words → every output word equals its input word. Repeat with `IN_WIDTH = 5` and check wrap at `cnt = 4`.
6. Build with `PARALLEL_TO_SERIAL_MSB_FIRST_EN`, send word 0x01 → bits 0,0,0,0,0,0,0,1; `m_last` on the final bit.

Source files
------------

// File: rtl/parallel_to_serial.sv
// Parallel word to 1-bit serial stream with a one-word hold buffer for bubble-free output.
// Optional macro PARALLEL_TO_SERIAL_MSB_FIRST_EN selects MSB-first order (default LSB-first).
module parallel_to_serial #(
  parameter int IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_WIDTH-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_data,
  output logic                m_last
);

  localparam int CNT_W = $clog2(IN_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);

  logic [IN_WIDTH-1:0] shift_ff;
  logic [IN_WIDTH-1:0] shift_next;
  logic [IN_WIDTH-1:0] shifted;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic                busy;
  logic                busy_next;
  logic [IN_WIDTH-1:0] hold_ff;
  logic [IN_WIDTH-1:0] hold_next;
  logic                hold_valid;
  logic                hold_valid_next;

  logic accept;
  logic bit_hs;
  logic at_last;
  logic word_end;

  assign s_ready  = ~hold_valid;
  assign m_valid  = busy;
  assign at_last  = (cnt == CNT_LAST);
  assign m_last   = busy & at_last;
  assign accept   = s_valid & s_ready;
  assign bit_hs   = busy & m_ready;
  assign word_end = bit_hs & at_last;

`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
  assign m_data  = shift_ff[IN_WIDTH-1];
  assign shifted = {shift_ff[IN_WIDTH-2:0], 1'b0};
`else
  assign m_data  = shift_ff[0];
  assign shifted = {1'b0, shift_ff[IN_WIDTH-1:1]};
`endif

  always_comb begin
    shift_next      = shift_ff;
    cnt_next        = cnt;
    busy_next       = busy;
    hold_next       = hold_ff;
    hold_valid_next = hold_valid;

    if (word_end) begin
      // Held word has priority; a new accept cannot coincide since s_ready is low.
      if (hold_valid) begin
        shift_next      = hold_ff;
        hold_valid_next = 1'b0;
        cnt_next        = '0;
        busy_next       = 1'b1;
      end else if (accept) begin
        shift_next = s_data;
        cnt_next   = '0;
        busy_next  = 1'b1;
      end else begin
        // Clear so an idle output reads 0 rather than a stale bit.
        shift_next = '0;
        cnt_next   = '0;
        busy_next  = 1'b0;
      end
    end else begin
      if (bit_hs) begin
        shift_next = shifted;
        cnt_next   = cnt + CNT_W'(1);
      end
      if (accept) begin
        if (!busy) begin
          shift_next = s_data;
          cnt_next   = '0;
          busy_next  = 1'b1;
        end else begin
          hold_next       = s_data;
          hold_valid_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shift_ff   <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      hold_ff    <= '0;
      hold_valid <= 1'b0;
    end else begin
      shift_ff   <= shift_next;
      cnt        <= cnt_next;
      busy       <= busy_next;
      hold_ff    <= hold_next;
      hold_valid <= hold_valid_next;
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Random and directed stimulus for parallel_to_serial (widths 8 and 5) against a word-queue
// reference model plus a deserialising receiver that rebuilds each word from the serial stream.
module tb_parallel_to_serial;

  localparam int W  = 8;
  localparam int W5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         aresetn, s_valid, s_ready, m_valid, m_ready, m_data, m_last;
  logic [W-1:0] s_data;
  logic          aresetn5, s_valid5, s_ready5, m_valid5, m_ready5, m_data5, m_last5;
  logic [W5-1:0] s_data5;

  int checks   = 0;
  int failures = 0;
  bit done5    = 1'b0;

  parallel_to_serial #(.IN_WIDTH(W)) dut (
    .clk(clk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  parallel_to_serial #(.IN_WIDTH(W5)) dut5 (
    .clk(clk), .aresetn(aresetn5), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
    .m_valid(m_valid5), .m_ready(m_ready5), .m_data(m_data5), .m_last(m_last5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Position within the word of the pos-th transmitted bit.
  function automatic int bit_index(input int pos, input int w);
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
    return w - 1 - pos;
`else
    return pos;
`endif
  endfunction

  // Width-8 model: words owned by the block (in flight + held), bits already sent of the front one.
  logic [W-1:0] q8[$];
  logic [W-1:0] sent8[$];
  int           pos8 = 0;
  logic [W-1:0] rx8 = '0;
  int           rx_idx8 = 0;

  task automatic cycle8(input logic sv, input logic [W-1:0] sd, input logic mr);
    logic exp_valid, exp_ready, acc, hs;
    logic [W-1:0] front, exp_word;
    s_valid = sv; s_data = sd; m_ready = mr;
    exp_valid = (q8.size() > 0);
    exp_ready = (q8.size() < 2);
    check("m_valid", 32'(m_valid), 32'(exp_valid));
    check("s_ready", 32'(s_ready), 32'(exp_ready));
    if (exp_valid) begin
      front = q8[0];
      check("m_data", 32'(m_data), 32'(front[bit_index(pos8, W)]));
      check("m_last", 32'(m_last), 32'(pos8 == W - 1));
    end
    acc = sv & exp_ready;
    hs  = exp_valid & mr;
    if (hs) begin
      rx8[bit_index(rx_idx8, W)] = m_data;
      if (m_last || rx_idx8 == W - 1) begin
        exp_word = (sent8.size() > 0) ? sent8.pop_front() : ~rx8;
        check("rx_word", 32'(rx8), 32'(exp_word));
        $display("word rx=0x%02h exp=0x%02h", rx8, exp_word);
        rx8 = '0; rx_idx8 = 0;
      end else begin
        rx_idx8++;
      end
    end
    @(posedge clk);
    if (hs) begin
      pos8++;
      if (pos8 == W) begin
        void'(q8.pop_front());
        pos8 = 0;
      end
    end
    if (acc) begin
      q8.push_back(sd);
      sent8.push_back(sd);
    end
    @(negedge clk);
  endtask

  task automatic drain8(input string tag);
    int n = 0;
    while (q8.size() > 0 && n < 500) begin
      cycle8(1'b0, '0, 1'($urandom_range(0, 1)));
      n++;
    end
    check(tag, 32'(q8.size()), 32'd0);
  endtask

  task automatic async_reset8();
    #2 aresetn = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data",  32'(m_data),  32'd0);
    check("rst_m_last",  32'(m_last),  32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    q8.delete(); sent8.delete();
    pos8 = 0; rx8 = '0; rx_idx8 = 0;
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    int accepted;
    int n;
    aresetn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data",  32'(m_data),  32'd0);
    check("rst_m_last",  32'(m_last),  32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    aresetn = 1'b1;
    repeat (2) cycle8(1'b0, '0, 1'b1);

    // Single word, continuous ready
    cycle8(1'b1, 8'hA5, 1'b1);
    repeat (9) cycle8(1'b0, '0, 1'b1);

    // Back-to-back words through the hold buffer
    cycle8(1'b1, 8'h3C, 1'b1);
    cycle8(1'b1, 8'hFF, 1'b1);
    repeat (17) cycle8(1'b0, '0, 1'b1);

    // Random backpressure
    cycle8(1'b1, 8'h81, 1'($urandom_range(0, 1)));
    drain8("drain_stall");

    // Asynchronous reset with a partial word in flight and a full hold buffer
    cycle8(1'b1, 8'hF0, 1'b1);
    repeat (3) cycle8(1'b0, '0, 1'b1);
    cycle8(1'b1, 8'h0F, 1'b0);
    cycle8(1'b0, '0, 1'b0);
    async_reset8();
    cycle8(1'b1, 8'h5A, 1'b1);
    drain8("drain_after_rst");

    // 100 random words with random valid/ready
    accepted = 0; n = 0;
    while (accepted < 100 && n < 5000) begin
      if (q8.size() < 2 && ($urandom_range(0, 3) != 0)) accepted++;
      else if (q8.size() >= 2) begin end
      cycle8(1'(q8.size() < 2 ? 1 : $urandom_range(0, 1)) & 1'(accepted <= 100),
             W'($urandom), 1'($urandom_range(0, 1)));
      n++;
    end
    drain8("drain_random");
    check("sent8_empty", 32'(sent8.size()), 32'd0);

    n = 0;
    while (!done5 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("w5_done", 32'(done5), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Width-5 instance: random traffic, exercises the non-power-of-two counter wrap.
  logic [W5-1:0] q5[$];
  logic [W5-1:0] sent5[$];
  int            pos5 = 0;
  logic [W5-1:0] rx5 = '0;
  int            rx_idx5 = 0;

  task automatic cycle5(input logic sv, input logic [W5-1:0] sd, input logic mr);
    logic exp_valid, exp_ready, acc, hs;
    logic [W5-1:0] front, exp_word;
    s_valid5 = sv; s_data5 = sd; m_ready5 = mr;
    exp_valid = (q5.size() > 0);
    exp_ready = (q5.size() < 2);
    check("w5_m_valid", 32'(m_valid5), 32'(exp_valid));
    check("w5_s_ready", 32'(s_ready5), 32'(exp_ready));
    if (exp_valid) begin
      front = q5[0];
      check("w5_m_data", 32'(m_data5), 32'(front[bit_index(pos5, W5)]));
      check("w5_m_last", 32'(m_last5), 32'(pos5 == W5 - 1));
    end
    acc = sv & exp_ready;
    hs  = exp_valid & mr;
    if (hs) begin
      rx5[bit_index(rx_idx5, W5)] = m_data5;
      if (m_last5 || rx_idx5 == W5 - 1) begin
        exp_word = (sent5.size() > 0) ? sent5.pop_front() : ~rx5;
        check("w5_rx_word", 32'(rx5), 32'(exp_word));
        $display("w5 word rx=0x%02h exp=0x%02h", rx5, exp_word);
        rx5 = '0; rx_idx5 = 0;
      end else begin
        rx_idx5++;
      end
    end
    @(posedge clk);
    if (hs) begin
      pos5++;
      if (pos5 == W5) begin
        void'(q5.pop_front());
        pos5 = 0;
      end
    end
    if (acc) begin
      q5.push_back(sd);
      sent5.push_back(sd);
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    aresetn5 = 1'b0; s_valid5 = 1'b0; s_data5 = '0; m_ready5 = 1'b0;
    repeat (3) @(negedge clk);
    aresetn5 = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cycle5(1'($urandom_range(0, 1)), W5'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    n = 0;
    while (q5.size() > 0 && n < 500) begin
      cycle5(1'b0, '0, 1'b1);
      n++;
    end
    check("w5_drain", 32'(q5.size()), 32'd0);
    check("w5_sent_empty", 32'(sent5.size()), 32'd0);
    done5 = 1'b1;
  end

endmodule
